// File: rtl/aud_capture.sv
// I2S-style capture: one 16-bit sample per LRC frame from the CAP_LRC channel, with SRAM write address.
// Optional `AUD_CAPTURE_PEAK_EN adds o_peak, the largest stored magnitude since the last fresh start.
module aud_capture #(
    parameter int unsigned       ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = '1,
    parameter logic              CAP_LRC  = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_lrc,
    input  logic              i_adcdat,
    output logic [15:0]       o_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_len,
    output logic              o_busy,
`ifdef AUD_CAPTURE_PEAK_EN
    output logic [15:0]       o_peak,
`endif
    output logic              o_full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_STORE,
        S_PAUSED
    } state_t;

    state_t              state_q, state_d;
    logic                lrc_q;
    logic [3:0]          cnt_q, cnt_d;
    logic [15:0]         sh_q, sh_d;
    logic [15:0]         data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic                full_q, full_d;
    logic                pend_q, pend_d;
    logic                lrc_edge;
`ifdef AUD_CAPTURE_PEAK_EN
    logic [15:0]         peak_q, peak_d;
    logic [15:0]         mag;
`endif

    assign lrc_edge = (i_lrc == CAP_LRC) && (lrc_q != CAP_LRC);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        data_d  = data_q;
        addr_d  = addr_q;
        len_d   = len_q;
        full_d  = full_q;
        pend_d  = pend_q;
`ifdef AUD_CAPTURE_PEAK_EN
        peak_d  = peak_q;
        if (data_q == 16'h8000)
            mag = 16'h7FFF;
        else if (data_q[15])
            mag = ~data_q + 16'd1;
        else
            mag = data_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    len_d   = '0;
                    full_d  = 1'b0;
                    sh_d    = '0;
`ifdef AUD_CAPTURE_PEAK_EN
                    peak_d  = '0;
`endif
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_pause) begin
                    state_d = S_PAUSED;
                end else if (lrc_edge) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sh_d  = {sh_q[14:0], i_adcdat};
                cnt_d = cnt_q + 4'd1;
                if (i_pause) pend_d = 1'b1;
                // Output word and address are latched with the LSB so they hold until the next store.
                if (cnt_q == 4'd15) begin
                    data_d  = {sh_q[14:0], i_adcdat};
                    addr_d  = len_q;
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                len_d  = len_q + ADDR_W'(1);
                pend_d = 1'b0;
`ifdef AUD_CAPTURE_PEAK_EN
                if (mag > peak_q) peak_d = mag;
`endif
                if (addr_q == MAX_ADDR) begin
                    full_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (pend_q || i_pause) begin
                    state_d = S_PAUSED;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_PAUSED: begin
                if (i_start) state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
        // Stop overrides everything; a word completing in the same cycle is dropped unseen.
        if (i_stop) begin
            state_d = S_IDLE;
            pend_d  = 1'b0;
            data_d  = data_q;
            addr_d  = addr_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            lrc_q   <= ~CAP_LRC;
            cnt_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            full_q  <= 1'b0;
            pend_q  <= 1'b0;
`ifdef AUD_CAPTURE_PEAK_EN
            peak_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            lrc_q   <= i_lrc;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            full_q  <= full_d;
            pend_q  <= pend_d;
`ifdef AUD_CAPTURE_PEAK_EN
            peak_q  <= peak_d;
`endif
        end
    end

    assign o_data  = data_q;
    assign o_addr  = addr_q;
    assign o_valid = (state_q == S_STORE);
    assign o_len   = len_q;
    assign o_busy  = (state_q != S_IDLE);
    assign o_full  = full_q;
`ifdef AUD_CAPTURE_PEAK_EN
    assign o_peak  = peak_q;
`endif

endmodule

// File: tb/tb_aud_capture.sv
// Frame-level bench for aud_capture: a per-frame reference model predicts writes and status,
// a negedge monitor pops the expected writes whenever o_valid is seen.
module tb_aud_capture;

    localparam int unsigned   AW   = 20;
    localparam logic [AW-1:0] MAXA = 20'd3;
    localparam logic          CAP  = 1'b0;

    localparam int EV_NONE  = 0;
    localparam int EV_START = 1;
    localparam int EV_PAUSE = 2;
    localparam int EV_STOP  = 3;
    localparam int EV_SP    = 4;
    localparam int EV_RST   = 5;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          stop  = 1'b0;
    logic          lrc   = ~CAP;
    logic          adc   = 1'b0;
    logic [15:0]   o_data;
    logic [AW-1:0] o_addr;
    logic          o_valid;
    logic [AW-1:0] o_len;
    logic          o_busy;
    logic          o_full;
`ifdef AUD_CAPTURE_PEAK_EN
    logic [15:0]   o_peak;
`endif

    aud_capture #(
        .ADDR_W   (AW),
        .MAX_ADDR (MAXA),
        .CAP_LRC  (CAP)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_pause  (pause),
        .i_stop   (stop),
        .i_lrc    (lrc),
        .i_adcdat (adc),
        .o_data   (o_data),
        .o_addr   (o_addr),
        .o_valid  (o_valid),
        .o_len    (o_len),
        .o_busy   (o_busy),
`ifdef AUD_CAPTURE_PEAK_EN
        .o_peak   (o_peak),
`endif
        .o_full   (o_full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0]   d;
        logic [AW-1:0] a;
    } wr_t;
    wr_t exp_q[$];

    typedef enum {M_IDLE, M_ACTIVE, M_PAUSED} mode_t;
    mode_t       mode   = M_IDLE;
    int          m_len  = 0;
    bit          m_full = 0;
    int          m_peak = 0;
    logic [15:0] m_data = '0;
    int          m_addr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!rst && o_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: actual addr 0x%0h data 0x%0h, required no write", o_addr, o_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_data", o_data, e.d);
                check("wr_addr", o_addr, e.a);
            end
        end
    end

    function automatic int magnitude(input logic [15:0] w);
        int v;
        v = $signed(w);
        if (v < 0) v = -v;
        return (v > 32767) ? 32767 : v;
    endfunction

    // Control pulse seen while not mid-word (IDLE, waiting for an edge, or paused).
    task automatic ctrl(input int ev);
        if (ev == EV_STOP || ev == EV_SP) begin
            mode = M_IDLE;
        end else if (ev == EV_START && mode == M_IDLE) begin
            m_len = 0; m_full = 0; m_peak = 0; mode = M_ACTIVE;
        end else if (ev == EV_START && mode == M_PAUSED) begin
            mode = M_ACTIVE;
        end else if (ev == EV_PAUSE && mode == M_ACTIVE) begin
            mode = M_PAUSED;
        end
    endtask

    task automatic model_frame(input int ev, input int off, input logic [15:0] word);
        bit early, cap, pend, drop;
        early = (off <= 16);
        cap   = (mode == M_ACTIVE);
        pend  = 0;
        drop  = 0;
        if (ev == EV_RST) begin
            mode = M_IDLE; m_len = 0; m_full = 0; m_peak = 0; m_data = '0; m_addr = 0;
            return;
        end
        if (early) begin
            if (cap) begin
                if (ev == EV_STOP || ev == EV_SP) begin
                    drop = 1; mode = M_IDLE;
                end else if (ev == EV_PAUSE) begin
                    pend = 1;
                end
            end else begin
                ctrl(ev);
            end
        end
        if (cap && !drop) begin
            exp_q.push_back('{word, AW'(m_len)});
            m_data = word;
            m_addr = m_len;
            if (magnitude(word) > m_peak) m_peak = magnitude(word);
            if (m_len == int'(MAXA)) begin
                m_full = 1; mode = M_IDLE;
            end else if (pend) begin
                mode = M_PAUSED;
            end
            m_len++;
        end
        if (!early) ctrl(ev);
    endtask

    task automatic check_status();
        check("len", o_len, m_len);
        check("full", o_full, m_full);
        check("busy", o_busy, mode != M_IDLE);
        check("hold_data", o_data, m_data);
        check("hold_addr", o_addr, m_addr);
`ifdef AUD_CAPTURE_PEAK_EN
        check("peak", o_peak, m_peak);
`endif
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_valid"}, o_valid, 0);
        check({name, "_data"}, o_data, 0);
        check({name, "_addr"}, o_addr, 0);
        check({name, "_len"}, o_len, 0);
        check({name, "_full"}, o_full, 0);
        check({name, "_busy"}, o_busy, 0);
`ifdef AUD_CAPTURE_PEAK_EN
        check({name, "_peak"}, o_peak, 0);
`endif
    endtask

    // One 40-cycle LRC frame; t=0 is the capture edge, data bits at t=1..16 MSB first.
    task automatic run_frame(input int ev, input int off, input logic [15:0] word);
        for (int t = 0; t < 40; t++) begin
            @(posedge clk);
            #1;
            lrc   = (t < 20) ? CAP : ~CAP;
            adc   = (t >= 1 && t <= 16) ? word[16 - t] : 1'($urandom);
            start = (ev == EV_START && t == off);
            pause = ((ev == EV_PAUSE || ev == EV_SP) && t == off);
            stop  = ((ev == EV_STOP || ev == EV_SP) && t == off);
            if (ev == EV_RST && t == off + 1) rst = 1'b0;
            if (ev == EV_RST && t == off) begin
                rst = 1'b1;
                #1;
                check_all_zero("async_rst");
            end
            if (t == 0) begin
                @(negedge clk);
                check_status();
                model_frame(ev, off, word);
            end
            if ((ev == EV_STOP || ev == EV_SP) && t == off + 1) begin
                @(negedge clk);
                check("busy_after_stop", o_busy, 0);
            end
        end
    endtask

    initial begin
        int ev, off, r;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        run_frame(EV_START, 25, 16'h0000);
        run_frame(EV_NONE,  0,  16'hC001);
        run_frame(EV_NONE,  0,  16'hA001);
        run_frame(EV_NONE,  0,  16'h9001);
        run_frame(EV_STOP,  25, 16'h1234);
        run_frame(EV_START, 30, 16'h0000);
        run_frame(EV_NONE,  0,  16'h1111);
        run_frame(EV_STOP,  8,  16'h2222);
        run_frame(EV_START, 22, 16'h0000);
        run_frame(EV_NONE,  0,  16'h3333);
        run_frame(EV_STOP,  21, 16'h4444);
        run_frame(EV_START, 5,  16'h0000);
        run_frame(EV_PAUSE, 5,  16'h5555);
        run_frame(EV_NONE,  0,  16'h6666);
        run_frame(EV_NONE,  0,  16'h7777);
        run_frame(EV_NONE,  0,  16'h8888);
        run_frame(EV_START, 30, 16'h9999);
        run_frame(EV_NONE,  0,  16'hAAAA);
        run_frame(EV_NONE,  0,  16'hBBBB);
        run_frame(EV_NONE,  0,  16'hCCCC);
        run_frame(EV_NONE,  0,  16'hDDDD);
        run_frame(EV_NONE,  0,  16'hEEEE);
        run_frame(EV_START, 24, 16'h0000);
        run_frame(EV_SP,    6,  16'h1357);
        run_frame(EV_START, 24, 16'h0000);
        run_frame(EV_NONE,  0,  16'h0100);
        run_frame(EV_NONE,  0,  16'hFE00);
        run_frame(EV_NONE,  0,  16'h8000);
        run_frame(EV_PAUSE, 30, 16'h0F0F);
        run_frame(EV_START, 30, 16'h0000);
        run_frame(EV_NONE,  0,  16'h2468);
        run_frame(EV_RST,   8,  16'hFFFF);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            ev = (r < 4) ? EV_NONE : (r < 6) ? EV_START : (r == 6 || r == 9) ? EV_PAUSE :
                 (r == 7) ? EV_STOP : EV_SP;
            off = $urandom_range(1, 36);
            if (off > 16) off += 3;
            run_frame(ev, off, 16'($urandom));
        end

        @(posedge clk);
        #1;
        start = 1'b0; pause = 1'b0; stop = 1'b0;
        @(negedge clk);
        check_status();
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
